div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative 32-bit divider in the EX stage; executes MIPS DIV/DIVU.
- Takes operands from the ID/EX pipeline register. These are register values or immediates already extended by the decode-stage extender.
- Returns {remainder, quotient} for the HI/LO write-back.
- Stalls the pipeline through a start/ready handshake; annul lets flushes cancel an in-flight divide.

Parameters:
WIDTH, 32, operand width; quotient and remainder are WIDTH bits each, result is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
signed_div  input  1  1 = DIV (two's-complement), 0 = DIVU
opdata1  input  WIDTH  dividend
opdata2  input  WIDTH  divisor
start  input  1  request divide; held high by EX until ready is seen
annul  input  1  cancel current operation (pipeline flush/exception)
result  output  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}
ready  output  1  result valid
busy  output  1  high in every state except FREE; drives the EX stall request

Behaviour:
- States: FREE, BYZERO, ON, END.
- On rst (asynchronous):
  - state=FREE; result=0; ready=0; busy=0.
  - Iteration counter and internal registers cleared.
  - Applies immediately, including mid-operation.
- Priority is rst > annul > everything else.
- annul=1 at any edge: state becomes FREE, ready=0, result=0. A start sampled on the same edge is ignored.
- FREE:
  - start=1 and opdata2==0: go to BYZERO.
  - start=1 and opdata2!=0: go to ON. At that same edge (E0), capture the operands and sign-flag.
    - signed_div=1: capture the magnitudes of both operands, plus negq = op1[31]^op2[31] and negr = op1[31].
    - signed_div=0: capture the raw operands; negq = negr = 0.
    - Clear the counter.
  - Operand changes after E0 are ignored.
- BYZERO: one cycle, then go to END with result=0. MIPS leaves this result undefined; we fix it at 0.
- ON:
  - One restoring-division step per cycle. Use a (2*WIDTH+1)-bit shift register holding {partial remainder, dividend}.
  - Each step: shift left 1; trial-subtract the divisor from the upper part. If non-negative, keep the difference and set the quotient bit; otherwise restore and clear the bit.
  - The counter runs 0..31. On the edge completing the 32nd step (E32), go to END.
  - On that edge, load result = {negr ? -rem : rem, negq ? -quo : quo} and set ready=1.
  - start remaining high during ON has no effect.
- END:
  - ready=1 and result held stable while start=1.
  - On the first edge with start=0: go to FREE, ready=0, result=0.
  - A new divide therefore needs start to drop for at least one cycle.
- Latency (start sampled at E0):
  - Non-zero divisor: ready is visible after E32, i.e. 33 edges.
  - Zero divisor: ready is visible after E1.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of the magnitude path naturally; no special case.
  - Unsigned 0xFFFFFFFF / 1 gives quotient 0xFFFFFFFF, remainder 0.
- busy is a registered output: 1 in BYZERO, ON and END; 0 in FREE.

Test Plan:
- DIVU 100 / 7, start held → ready rises 33 edges after start sampled; result = {0x00000002, 0x0000000E}; start dropped → next edge ready=0, result=0, busy=0.
- DIV -7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also DIV 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 0x00000001 → {0x00000000, 0xFFFFFFFF}.
- Divide by zero (either signedness, opdata1=0x1234) → ready=1 two edges after start, result=0, busy high for exactly those cycles until start drops.
- annul asserted 10 cycles into ON, with opdata changed mid-operation → state FREE next edge, ready never asserts, result=0. A fresh DIVU 9 / 3 afterwards returns {0, 3} at normal latency.
- rst pulsed asynchronously (between edges) mid-ON and in END → outputs zero immediately. After release, a back-to-back sequence (drop start for one cycle, then start again) completes two divides with correct results.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// Handshake: EX raises start and holds it (with operands stable at least on
// the first edge) until ready is seen; ready/result stay valid while start is
// high, and the divider returns to idle on the first edge where start is low.
interface div_unit_if #(parameter int WIDTH = 32);
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               start;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               busy;
  logic [1:0]         state_dbg;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, busy, state_dbg
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, busy, state_dbg
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// result is {remainder, quotient} for the HI/LO write-back.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2*WIDTH:0]     shreg, shreg_n;
  logic [WIDTH-1:0]     divisor, divisor_n;
  logic                 negq, negq_n, negr, negr_n;
  logic [2*WIDTH-1:0]   result, result_n;
  logic                 ready, ready_n, busy, busy_n;

  logic [2*WIDTH:0]     shifted, step;
  logic [WIDTH+1:0]     trial;
  logic [WIDTH-1:0]     mag1, mag2, quo, rem;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    divisor_n = divisor;
    negq_n    = negq;
    negr_n    = negr;
    result_n  = result;
    ready_n   = ready;

    // Signed operands are reduced to magnitudes; the signs are reapplied at the end.
    mag1 = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
    mag2 = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

    shifted = shreg << 1;
    trial   = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
    step    = trial[WIDTH+1] ? shifted
                             : {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    quo     = step[WIDTH-1:0];
    rem     = step[2*WIDTH-1:WIDTH];

    if (bus.annul) begin
      state_n  = FREE;
      ready_n  = 1'b0;
      result_n = '0;
    end else begin
      case (state)
        FREE: begin
          if (bus.start) begin
            if (bus.opdata2 == '0) begin
              state_n = BYZERO;
            end else begin
              state_n   = ON;
              shreg_n   = {{(WIDTH+1){1'b0}}, mag1};
              divisor_n = mag2;
              negq_n    = bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
              negr_n    = bus.signed_div & bus.opdata1[WIDTH-1];
              cnt_n     = '0;
            end
          end
        end
        BYZERO: begin
          state_n  = END;
          result_n = '0;
          ready_n  = 1'b1;
        end
        ON: begin
          shreg_n = step;
          cnt_n   = cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            state_n  = END;
            result_n = {negr ? -rem : rem, negq ? -quo : quo};
            ready_n  = 1'b1;
          end
        end
        END: begin
          if (!bus.start) begin
            state_n  = FREE;
            ready_n  = 1'b0;
            result_n = '0;
          end
        end
        default: begin
          state_n = FREE;
        end
      endcase
    end

    busy_n = (state_n != FREE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FREE;
      cnt     <= '0;
      shreg   <= '0;
      divisor <= '0;
      negq    <= 1'b0;
      negr    <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      divisor <= divisor_n;
      negq    <= negq_n;
      negr    <= negr_n;
      result  <= result_n;
      ready   <= ready_n;
      busy    <= busy_n;
    end
  end

  assign bus.result    = result;
  assign bus.ready     = ready;
  assign bus.busy      = busy;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides
// scored against a plain-arithmetic reference model.
module tb_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] exp_q[$];
  logic        rdy_q;

  div_unit_if #(.WIDTH(32)) ifc ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: truncating division, remainder follows dividend, x/0 -> 0.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // monitor: compare on every rising edge of ready
  always @(negedge clk) begin
    if (ifc.ready && !rdy_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=%h required=none", ifc.result);
      end else begin
        chk("result", ifc.result, exp_q.pop_front());
      end
    end
    rdy_q = ifc.ready;
  end

  // driver: issue one divide, measure latency, optionally drop start afterwards
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] req, input bit drop);
    int n;
    int lat;
    lat = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    ifc.signed_div = sgn;
    ifc.opdata1    = a;
    ifc.opdata2    = b;
    ifc.start      = 1'b1;
    exp_q.push_back(req);
    @(posedge clk);
    #1;
    n = 1;
    chk("busy_after_start", 64'(ifc.busy), 64'd1);
    // operands may change once captured
    ifc.opdata1 = $urandom;
    ifc.opdata2 = $urandom;
    while (!ifc.ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    chk("held_ready", 64'(ifc.ready), 64'd1);
    chk("held_result", ifc.result, req);
    chk("held_busy", 64'(ifc.busy), 64'd1);
    if (drop) begin
      @(negedge clk);
      ifc.start = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_ready", 64'(ifc.ready), 64'd0);
      chk("drop_result", ifc.result, 64'd0);
      chk("drop_busy", 64'(ifc.busy), 64'd0);
    end
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    checks         = 0;
    failures       = 0;
    rdy_q          = 1'b0;
    rst            = 1'b1;
    ifc.signed_div = 1'b0;
    ifc.opdata1    = '0;
    ifc.opdata2    = '0;
    ifc.start      = 1'b0;
    ifc.annul      = 1'b0;
    #2;
    chk("reset_ready", 64'(ifc.ready), 64'd0);
    chk("reset_result", ifc.result, 64'd0);
    chk("reset_busy", 64'(ifc.busy), 64'd0);
    chk("reset_state", 64'(ifc.state_dbg), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // directed corner cases
    run_div(1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 1'b1);
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1);
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 1'b1);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1'b1);
    run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, {32'h00000000, 32'hFFFFFFFF}, 1'b1);
    run_div(1'b0, 32'h00001234, 32'h00000000, 64'd0, 1'b1);
    run_div(1'b1, 32'h00001234, 32'h00000000, 64'd0, 1'b1);

    // annul mid-operation, with operands changed underneath
    @(negedge clk);
    ifc.signed_div = 1'b0;
    ifc.opdata1    = $urandom;
    ifc.opdata2    = $urandom_range(1, 1000);
    ifc.start      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    ifc.opdata1 = $urandom;
    ifc.opdata2 = $urandom;
    ifc.annul   = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_state", 64'(ifc.state_dbg), 64'd0);
    chk("annul_ready", 64'(ifc.ready), 64'd0);
    chk("annul_result", ifc.result, 64'd0);
    chk("annul_busy", 64'(ifc.busy), 64'd0);
    @(negedge clk);
    ifc.annul = 1'b0;
    ifc.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("annul_no_ready", 64'(ifc.ready), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1);

    // async reset mid-ON
    @(negedge clk);
    ifc.signed_div = 1'b1;
    ifc.opdata1    = 32'd12345;
    ifc.opdata2    = 32'd17;
    ifc.start      = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_on_ready", 64'(ifc.ready), 64'd0);
    chk("rst_on_result", ifc.result, 64'd0);
    chk("rst_on_busy", 64'(ifc.busy), 64'd0);
    chk("rst_on_state", 64'(ifc.state_dbg), 64'd0);
    @(negedge clk);
    ifc.start = 1'b0;
    rst       = 1'b0;

    // async reset while holding a result in END
    run_div(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_end_ready", 64'(ifc.ready), 64'd0);
    chk("rst_end_result", ifc.result, 64'd0);
    chk("rst_end_busy", 64'(ifc.busy), 64'd0);
    @(negedge clk);
    ifc.start = 1'b0;
    rst       = 1'b0;

    // back-to-back with a single idle cycle
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b1);
    run_div(1'b0, 32'hDEADBEEF, 32'h10, {32'h0000000F, 32'h0DEADBEE}, 1'b1);

    // random divides against the reference model
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      run_div(sgn, a, b, ref_div(sgn, a, b), 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
